fft_4pt_stream: RTL and testbench

Streaming, parametrised 4-point radix-2 FFT/IFFT engine with valid/ready handshakes on both sides.
- Accepts one complex sample per cycle in natural order and frames it in groups of 4.
- Computes forward or inverse transform, with optional 1/4 output scaling.
- Streams 4 bins out in natural order through a 2-bank output buffer that absorbs downstream backpressure.
- Successor to the parallel-I/O 4-point core; sits between the sample source and the spectral post-processing chain.

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft4_bfly.sv | 54 +++++
 rtl/fft_4pt_stream.sv | 112 +++++++++++
 tb/tb_fft_4pt_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types, constants and width helper for the streaming FFT engines
package fft_pkg;
  localparam int FFT_N = 4;
  localparam int RND = 2;
  typedef enum logic {EMPTY, FULL} bank_st_e;
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;
  function automatic int out_width(input int dw);
    return dw + 2;
  endfunction
endpackage

// File: rtl/fft4_bfly.sv
// fft4_bfly: combinational radix-2 4-point butterfly with direction select and 1/4 rounding
module fft4_bfly
  import fft_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = out_width(DW)
) (
  input  logic signed [DW-1:0] x_re [FFT_N],
  input  logic signed [DW-1:0] x_im [FFT_N],
  input  logic                 inverse,
  input  logic                 scale,
  output logic signed [OW-1:0] y_re [FFT_N],
  output logic signed [OW-1:0] y_im [FFT_N]
);
  logic signed [DW:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [OW-1:0] fr [FFT_N];
  logic signed [OW-1:0] fi [FFT_N];
  logic signed [OW-1:0] pr, pi, qr, qi;

  function automatic logic signed [OW-1:0] rnd(input logic signed [OW-1:0] v);
    logic signed [OW:0] t;
    t = (OW+1)'(v) + (OW+1)'(RND);
    t = t >>> 2;
    return t[OW-1:0];
  endfunction

  // two radix-2 stages; the odd bins swap between forward and inverse twiddle
  always_comb begin
    ar = (DW+1)'(x_re[0]) + (DW+1)'(x_re[2]);
    ai = (DW+1)'(x_im[0]) + (DW+1)'(x_im[2]);
    br = (DW+1)'(x_re[0]) - (DW+1)'(x_re[2]);
    bi = (DW+1)'(x_im[0]) - (DW+1)'(x_im[2]);
    cr = (DW+1)'(x_re[1]) + (DW+1)'(x_re[3]);
    ci = (DW+1)'(x_im[1]) + (DW+1)'(x_im[3]);
    dr = (DW+1)'(x_re[1]) - (DW+1)'(x_re[3]);
    di = (DW+1)'(x_im[1]) - (DW+1)'(x_im[3]);
    pr = OW'(br) + OW'(di);
    pi = OW'(bi) - OW'(dr);
    qr = OW'(br) - OW'(di);
    qi = OW'(bi) + OW'(dr);
    fr[0] = OW'(ar) + OW'(cr);
    fi[0] = OW'(ai) + OW'(ci);
    fr[2] = OW'(ar) - OW'(cr);
    fi[2] = OW'(ai) - OW'(ci);
    fr[1] = inverse ? qr : pr;
    fi[1] = inverse ? qi : pi;
    fr[3] = inverse ? pr : qr;
    fi[3] = inverse ? pi : qi;
    for (int k = 0; k < FFT_N; k++) begin
      y_re[k] = scale ? rnd(fr[k]) : fr[k];
      y_im[k] = scale ? rnd(fi[k]) : fi[k];
    end
  end
endmodule

// File: rtl/fft_4pt_stream.sv
// fft_4pt_stream: streaming 4-point FFT/IFFT with sample collector and 2-bank output buffer
module fft_4pt_stream
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = out_width(DATA_WIDTH),
  parameter int NBANKS     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_re,
  input  logic signed [DATA_WIDTH-1:0] s_im,
  input  logic                        s_last,
  input  logic                        cfg_inverse,
  input  logic                        cfg_scale,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_re,
  output logic signed [OUT_WIDTH-1:0] m_im,
  output logic [1:0]                  m_idx,
  output logic                        m_last,
  output logic                        frame_err
);
  logic signed [DATA_WIDTH-1:0] col_re [FFT_N];
  logic signed [DATA_WIDTH-1:0] col_im [FFT_N];
  logic signed [OUT_WIDTH-1:0] y_re [FFT_N];
  logic signed [OUT_WIDTH-1:0] y_im [FFT_N];
  logic signed [OUT_WIDTH-1:0] bk_re [NBANKS][FFT_N];
  logic signed [OUT_WIDTH-1:0] bk_im [NBANKS][FFT_N];
  bank_st_e st [NBANKS];
  logic [1:0] wr_cnt, rd_idx;
  logic col_full, inv_l, scl_l, old, rd, wb, any_empty, xfer, accept, hs, bad_last;

  fft4_bfly #(.DW(DATA_WIDTH), .OW(OUT_WIDTH)) u_bfly (
    .x_re(col_re),
    .x_im(col_im),
    .inverse(inv_l),
    .scale(scl_l),
    .y_re(y_re),
    .y_im(y_im)
  );

  // handshakes, bank selection (fill lowest empty, drain oldest full) and output mux
  always_comb begin
    any_empty = st[0] == EMPTY || st[1] == EMPTY;
    wb = st[0] != EMPTY;
    rd = (st[0] == FULL && st[1] == FULL) ? old : st[1] == FULL;
    xfer = col_full && any_empty;
    s_ready = !col_full || any_empty;
    accept = s_valid && s_ready;
    bad_last = s_last && wr_cnt != 2'd3;
    m_valid = st[rd] == FULL;
    hs = m_valid && m_ready;
    m_re = m_valid ? bk_re[rd][rd_idx] : '0;
    m_im = m_valid ? bk_im[rd][rd_idx] : '0;
    m_idx = rd_idx;
    m_last = rd_idx == 2'd3;
  end

  // control state: collector count, bank occupancy, fill order, read index, framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      col_full <= 1'b0;
      inv_l <= 1'b0;
      scl_l <= 1'b0;
      frame_err <= 1'b0;
      old <= 1'b0;
      rd_idx <= '0;
      for (int i = 0; i < NBANKS; i++) st[i] <= EMPTY;
    end else begin
      if (xfer) begin
        st[wb] <= FULL;
        old <= st[!wb] == FULL ? !wb : wb;
        col_full <= 1'b0;
      end
      if (hs) begin
        rd_idx <= rd_idx + 2'd1;
        if (rd_idx == 2'd3) st[rd] <= EMPTY;
      end
      if (accept && bad_last) begin
        frame_err <= 1'b1;
        wr_cnt <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 2'd1;
        if (wr_cnt == 2'd0) begin
          inv_l <= cfg_inverse;
          scl_l <= cfg_scale;
        end
        if (wr_cnt == 2'd3) begin
          col_full <= 1'b1;
          if (!s_last) frame_err <= 1'b1;
        end
      end
    end
  end

  // datapath storage: incoming samples and butterfly results need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      col_re[wr_cnt] <= s_re;
      col_im[wr_cnt] <= s_im;
    end
    if (xfer)
      for (int k = 0; k < FFT_N; k++) begin
        bk_re[wb][k] <= y_re[k];
        bk_im[wb][k] <= y_im[k];
      end
  end
endmodule

// File: tb/tb_fft_4pt_stream.sv
// tb_fft_4pt_stream: randomized scoreboard bench against a direct DFT reference
module tb_fft_4pt_stream;
  import fft_pkg::*;
  localparam int DW = 16;
  localparam int OW = DW + 2;

  logic clk = 0, rst_n = 0, s_valid = 0, s_ready, s_last = 0, cfg_inverse = 0, cfg_scale = 0;
  logic m_valid, m_ready = 1, m_last, frame_err;
  logic signed [DW-1:0] s_re = '0, s_im = '0;
  logic signed [OW-1:0] m_re, m_im;
  logic [1:0] m_idx;

  typedef struct { cplx_t v; int idx; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  bit gaps = 0, done = 0;
  int fr[4], fi[4];

  fft_4pt_stream #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .cfg_inverse(cfg_inverse), .cfg_scale(cfg_scale), .m_valid(m_valid),
    .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // X[k] = sum_n x[n] * w^(n*k), w = -j (forward) or +j (inverse), optional (X+2)>>>2
  task automatic model(input int xr[4], input int xi[4], input bit inv, input bit scl);
    exp_t e;
    int ar, ai, m;
    for (int k = 0; k < 4; k++) begin
      ar = 0;
      ai = 0;
      for (int n = 0; n < 4; n++) begin
        m = (n * k * (inv ? 1 : 3)) % 4;
        case (m)
          0: begin ar += xr[n]; ai += xi[n]; end
          1: begin ar -= xi[n]; ai += xr[n]; end
          2: begin ar -= xr[n]; ai -= xi[n]; end
          default: begin ar += xi[n]; ai -= xr[n]; end
        endcase
      end
      if (scl) begin
        ar = (ar + 2) >>> 2;
        ai = (ai + 2) >>> 2;
      end
      e.v.re = ar;
      e.v.im = ai;
      e.idx = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic put(input int re, input int im, input bit last, input bit inv, input bit scl);
    int n = 0;
    bit acc = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_valid = 0;
      @(posedge clk);
      #1;
    end
    s_valid = 1;
    s_re = DW'(re);
    s_im = DW'(im);
    s_last = last;
    cfg_inverse = inv;
    cfg_scale = scl;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    chk("accept", acc, 1);
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic send_frame(input int xr[4], input int xi[4], input bit inv, input bit scl, input bit last3);
    model(xr, xi, inv, scl);
    for (int n = 0; n < 4; n++) put(xr[n], xi[n], n == 3 ? last3 : 1'b0, inv, scl);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 4; n++) begin
      fr[n] = int'($signed(16'($urandom)));
      fi[n] = int'($signed(16'($urandom)));
    end
  endtask

  // monitor: every accepted output bin is checked against the oldest expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected bin: got re=%0d im=%0d idx=%0d", m_re, m_im, m_idx);
      end else begin
        e = exp_q.pop_front();
        if (int'(m_re) != e.v.re || int'(m_im) != e.v.im || int'(m_idx) != e.idx || m_last != (e.idx == 3)) begin
          errors++;
          $display("FAIL bin: got re=%0d im=%0d idx=%0d last=%0d want re=%0d im=%0d idx=%0d",
                   m_re, m_im, m_idx, m_last, e.v.re, e.v.im, e.idx);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    // forward, unscaled, with latency check
    fr = '{1, 2, 3, 4};
    fi = '{0, 0, 0, 0};
    send_frame(fr, fi, 0, 0, 1);
    chk("lat_pre_valid", m_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", m_valid, 1);
    chk("lat_x0", m_re, 10);
    send_frame(fr, fi, 1, 0, 1);
    send_frame(fr, fi, 0, 1, 1);
    fr = '{-32768, -32768, -32768, -32768};
    send_frame(fr, fi, 0, 0, 1);
    drain();
    // s_last on the second sample, then a clean frame
    put(5, 5, 0, 0, 0);
    put(6, 6, 1, 0, 0);
    chk("err_set", frame_err, 1);
    fr = '{7, -3, 100, 9};
    fi = '{-1, 2, 0, 55};
    send_frame(fr, fi, 1, 0, 1);
    drain();
    chk("err_sticky", frame_err, 1);
    // backpressure: three frames, nothing consumed
    m_ready = 0;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      send_frame(fr, fi, f[0], 0, 1);
    end
    chk("bp_ready_low", s_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ready_hold", s_ready, 0);
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready_release", s_ready, i == 3);
    end
    drain();
    // random traffic with random backpressure and input bubbles
    gaps = 1;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          rand_frame();
          send_frame(fr, fi, $urandom_range(0, 1), $urandom_range(0, 1), 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = $urandom_range(0, 2) != 0;
        end
      end
    join
    gaps = 0;
    m_ready = 1;
    drain();
    // reset with a full bank stalled and a partial frame in the collector
    m_ready = 0;
    rand_frame();
    send_frame(fr, fi, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", m_valid, 1);
    put(11, 12, 0, 0, 0);
    put(13, 14, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    chk("rst_async_valid", m_valid, 0);
    chk("rst_async_re", m_re, 0);
    chk("rst_async_ready", s_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    m_ready = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_err", frame_err, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_quiet", m_valid, 0);
    // missing s_last on sample 3: flagged but still processed
    fr = '{3, -8, 12, 1};
    fi = '{4, 4, -9, 0};
    send_frame(fr, fi, 0, 1, 0);
    chk("err_nolast", frame_err, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
